// File: rtl/frame_ring_pkg.sv
// Shared constants and helpers for the display-domain frame-slot ring.
// Region base bytes, default geometry and address composition.
package frame_ring_pkg;

    localparam logic [7:0] SCALER_BASE   = 8'h68;
    localparam logic [7:0] MAIN_BASE_DEF = 8'h70;
    localparam logic [7:0] OVL_BASE_DEF  = 8'h78;

    localparam int NUM_STAGES_DEF = 4;
    localparam int PTR_W_DEF      = 3;
    localparam int ADDR_W_DEF     = 8;
    localparam int OVL_TAP_DEF    = 2;
    localparam int CNT_W_DEF      = 16;

    // Slot-ring event chosen for the current cycle, highest priority first.
    typedef enum logic [1:0] {
        EV_IDLE       = 2'd0,
        EV_ADV_READY  = 2'd1,
        EV_ADV_DIRECT = 2'd2,
        EV_WR_SWAP    = 2'd3
    } ring_ev_e;

    // Upper bits come from the region base, low ptr_w bits select the slot.
    function automatic logic [31:0] addr_compose(input logic [31:0] base,
                                                 input logic [31:0] ptr,
                                                 input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (base & ~mask) | (ptr & mask);
    endfunction

endpackage

// File: rtl/frame_ring_if.sv
// Control and address bundle between the frame-ring controller and its
// writer, reader engines and status consumers.
interface frame_ring_if #(
    parameter int NUM_STAGES = 4,
    parameter int PTR_W      = 3,
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16
);

    logic                        d_frame_swap_toggle;
    logic                        d_frame_wr_done;
    logic                        d_min_delay_path_sel;
    logic                        d_freeze_i;
    logic                        d_clr_cnt_i;

    logic [ADDR_W-1:0]           d_frame_process_addr_o;
    logic [ADDR_W-1:0]           d_frame_overlay_draw_addr_o;
    logic [ADDR_W-1:0]           d_frame_read_addr_o;
    logic [ADDR_W-1:0]           d_frame_overlay_rd_addr_o;
    logic [ADDR_W-1:0]           d_frame_overlay_wr_addr_o;
    logic [PTR_W-1:0]            d_frame_wr_ptr_o;
    logic [NUM_STAGES*PTR_W-1:0] d_stage_ptr_o;
    logic                        d_ready_valid_o;
    logic                        d_swap_pulse_o;
    logic [CNT_W-1:0]            d_drop_cnt_o;
    logic [CNT_W-1:0]            d_repeat_cnt_o;

    modport master (
        input  d_frame_swap_toggle, d_frame_wr_done, d_min_delay_path_sel,
               d_freeze_i, d_clr_cnt_i,
        output d_frame_process_addr_o, d_frame_overlay_draw_addr_o,
               d_frame_read_addr_o, d_frame_overlay_rd_addr_o,
               d_frame_overlay_wr_addr_o, d_frame_wr_ptr_o, d_stage_ptr_o,
               d_ready_valid_o, d_swap_pulse_o, d_drop_cnt_o, d_repeat_cnt_o
    );

    modport slave (
        output d_frame_swap_toggle, d_frame_wr_done, d_min_delay_path_sel,
               d_freeze_i, d_clr_cnt_i,
        input  d_frame_process_addr_o, d_frame_overlay_draw_addr_o,
               d_frame_read_addr_o, d_frame_overlay_rd_addr_o,
               d_frame_overlay_wr_addr_o, d_frame_wr_ptr_o, d_stage_ptr_o,
               d_ready_valid_o, d_swap_pulse_o, d_drop_cnt_o, d_repeat_cnt_o
    );

endinterface

// File: rtl/frame_ring_sat_cnt.sv
// Saturating event counter with synchronous clear; clear beats increment.
module frame_ring_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             disp_clk_i,
    input  logic             resetn_i,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge disp_clk_i) begin
        if (!resetn_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/frame_ring_controller.sv
// Frame-slot rotation controller: write slot, ready slot and a reader
// pipeline form a ring of NUM_STAGES+2 slots that rotates on frame swaps.
module frame_ring_controller
    import frame_ring_pkg::*;
#(
    parameter int                NUM_STAGES = NUM_STAGES_DEF,
    parameter int                PTR_W      = PTR_W_DEF,
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] MAIN_BASE  = ADDR_W'(MAIN_BASE_DEF),
    parameter logic [ADDR_W-1:0] OVL_BASE   = ADDR_W'(OVL_BASE_DEF),
    parameter int                OVL_TAP    = OVL_TAP_DEF,
    parameter int                CNT_W      = CNT_W_DEF
) (
    input logic            disp_clk_i,
    input logic            resetn_i,
    frame_ring_if.master   ring
);

    logic [PTR_W-1:0] stage [NUM_STAGES];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rdy_ptr;
    logic [PTR_W-1:0] min_ptr;
    logic             rdy_vld;
    logic             swap_pulse;
    logic             tgl_p0;
    logic             swap_p1;

    logic             wr_done;
    logic             freeze;
    logic             adv;
    ring_ev_e         ev;

    assign wr_done = ring.d_frame_wr_done;
    assign freeze  = ring.d_freeze_i;

    function automatic logic [ADDR_W-1:0] main_addr(input logic [PTR_W-1:0] p);
        return ADDR_W'(addr_compose(32'(MAIN_BASE), 32'(p), PTR_W));
    endfunction

    function automatic logic [ADDR_W-1:0] ovl_addr(input logic [PTR_W-1:0] p);
        return ADDR_W'(addr_compose(32'(OVL_BASE), 32'(p), PTR_W));
    endfunction

    // A frozen pipeline never advances; wr_done alone only trades wr/ready.
    always_comb begin
        ev = EV_IDLE;
        if (swap_p1 && !freeze && rdy_vld) begin
            ev = EV_ADV_READY;
        end else if (swap_p1 && !freeze && wr_done) begin
            ev = EV_ADV_DIRECT;
        end else if (wr_done) begin
            ev = EV_WR_SWAP;
        end
    end

    assign adv = (ev == EV_ADV_READY) || (ev == EV_ADV_DIRECT);

    // p0: toggle capture, p1: edge detect, then pointer update
    always_ff @(posedge disp_clk_i) begin
        if (!resetn_i) begin
            wr_ptr     <= '0;
            rdy_ptr    <= PTR_W'(NUM_STAGES + 1);
            min_ptr    <= '0;
            rdy_vld    <= 1'b0;
            swap_pulse <= 1'b0;
            tgl_p0     <= 1'b0;
            swap_p1    <= 1'b0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage[i] <= PTR_W'(i + 1);
            end
        end else begin
            tgl_p0     <= ring.d_frame_swap_toggle;
            swap_p1    <= tgl_p0 ^ ring.d_frame_swap_toggle;
            swap_pulse <= adv;

            if (wr_done) begin
                min_ptr <= wr_ptr;
            end

            if (adv) begin
                for (int i = 1; i < NUM_STAGES; i++) begin
                    stage[i] <= stage[i-1];
                end
            end

            case (ev)
                EV_ADV_READY: begin
                    // A fresh frame overrides the pending ready one, which is dropped.
                    stage[0] <= wr_done ? wr_ptr : rdy_ptr;
                    rdy_ptr  <= stage[NUM_STAGES-1];
                    if (wr_done) begin
                        wr_ptr <= rdy_ptr;
                    end
                    rdy_vld  <= 1'b0;
                end
                EV_ADV_DIRECT: begin
                    stage[0] <= wr_ptr;
                    wr_ptr   <= stage[NUM_STAGES-1];
                end
                EV_WR_SWAP: begin
                    wr_ptr  <= rdy_ptr;
                    rdy_ptr <= wr_ptr;
                    rdy_vld <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    frame_ring_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .disp_clk_i (disp_clk_i),
        .resetn_i   (resetn_i),
        .inc        (wr_done & rdy_vld),
        .clr        (ring.d_clr_cnt_i),
        .cnt        (ring.d_drop_cnt_o)
    );

    frame_ring_sat_cnt #(.CNT_W(CNT_W)) u_repeat_cnt (
        .disp_clk_i (disp_clk_i),
        .resetn_i   (resetn_i),
        .inc        (swap_p1 & ~adv),
        .clr        (ring.d_clr_cnt_i),
        .cnt        (ring.d_repeat_cnt_o)
    );

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage_out
        assign ring.d_stage_ptr_o[g*PTR_W +: PTR_W] = stage[g];
    end

    assign ring.d_frame_process_addr_o      = main_addr(stage[0]);
    assign ring.d_frame_overlay_draw_addr_o = ovl_addr(stage[0]);
    assign ring.d_frame_read_addr_o         = ring.d_min_delay_path_sel ?
                                              main_addr(min_ptr) : main_addr(stage[1]);
    assign ring.d_frame_overlay_rd_addr_o   = ovl_addr(stage[1]);
    assign ring.d_frame_overlay_wr_addr_o   = ovl_addr(stage[OVL_TAP]);
    assign ring.d_frame_wr_ptr_o            = wr_ptr;
    assign ring.d_ready_valid_o             = rdy_vld;
    assign ring.d_swap_pulse_o              = swap_pulse;

endmodule

// File: doc/frame_ring_controller.md
# frame_ring_controller

Parametrised frame-slot rotation controller for the display clock domain. It owns a ring of NUM_STAGES+2 DDR frame slots: one write slot, one "ready" (latest completed) slot and a NUM_STAGES-deep reader pipeline (process, display, delay taps). On each frame-swap toggle it advances the reader pipeline and recycles the oldest slot to the writer. It adds freeze, direct promotion of a just-completed frame, and saturating drop/repeat statistics. It emits per-stage main and overlay base-address bytes to the DMA, scaler and overlay engines.

## Interface
- NUM_STAGES, 4, reader pipeline depth; range 2..(2**PTR_W)-2
- PTR_W, 3, slot pointer width
- ADDR_W, 8, address-byte width; must be > PTR_W
- MAIN_BASE, 8'h70, main frame region address byte
- OVL_BASE, 8'h78, overlay frame region address byte
- OVL_TAP, 2, stage index driving the overlay write address; range 1..NUM_STAGES-1
- CNT_W, 16, statistics counter width
- disp_clk_i  in  1  display clock; the only clock
- resetn_i  in  1  reset; synchronous, active-low
- d_frame_swap_toggle  in  1  level toggles once per display frame; synchronous to disp_clk_i
- d_frame_wr_done  in  1  one-cycle pulse; writer finished the current write slot
- d_min_delay_path_sel  in  1  read address follows the last written slot
- d_freeze_i  in  1  hold the reader pipeline
- d_clr_cnt_i  in  1  clear statistics
- d_frame_process_addr_o  out  ADDR_W  main address of stage 0
- d_frame_overlay_draw_addr_o  out  ADDR_W  overlay address of stage 0
- d_frame_read_addr_o  out  ADDR_W  main address of stage 1, or the min-delay slot
- d_frame_overlay_rd_addr_o  out  ADDR_W  overlay address of stage 1
- d_frame_overlay_wr_addr_o  out  ADDR_W  overlay address of stage OVL_TAP
- d_frame_wr_ptr_o  out  PTR_W  current write slot
- d_stage_ptr_o  out  NUM_STAGES*PTR_W  all stage pointers; stage 0 in the LSBs
- d_ready_valid_o  out  1  the ready slot holds an unconsumed frame
- d_swap_pulse_o  out  1  one-cycle pulse when the pipeline advanced
- d_drop_cnt_o / d_repeat_cnt_o  out  CNT_W  saturating statistics

## Operation
- Every address is {BASE[ADDR_W-1:PTR_W], ptr}.
- Reset values: wr=0; stage[i]=i+1; ready=NUM_STAGES+1; ready_valid=0; min-delay latch=0; counters=0; swap_pulse=0; edge register=0.
- A swap edge is detected when the registered toggle differs from the input.
- Priority per cycle, highest first:
  - A) Swap edge, not frozen, ready_valid=1: stage[0]<=(wr_done ? wr : ready); stage[i]<=stage[i-1]; freed slot F=stage[N-1]. If wr_done: wr<=old ready, ready<=F. Otherwise: ready<=F, wr unchanged. ready_valid<=0; swap_pulse.
  - B) Swap edge, not frozen, ready_valid=0, wr_done=1: stage[0]<=wr; stages shift; wr<=F; swap_pulse. This is direct promotion.
  - C) wr_done only (including while frozen or on a non-advancing swap edge): swap wr and ready; ready_valid<=1.
- An advancing swap edge is any A or B event.
- Drop counter: increments on every wr_done while ready_valid=1, because a completed frame is discarded.
- Repeat counter: increments on every swap edge that does not advance the pipeline (no new frame, or frozen).
- Counters saturate at all-ones. d_clr_cnt_i forces both to 0 and takes priority over increments.
- Min-delay latch: loads wr on every wr_done. When d_min_delay_path_sel=1, the read address uses the latch.
- Invariant: all NUM_STAGES+2 pointers remain a permutation of 0..NUM_STAGES+1.

## Timing
- Pointers, addresses and counters update on the clock edge after the event. Address outputs are combinational from registers.
- The swap edge takes 1 cycle from a toggle change to detection, then 1 more cycle to the pointer update.
- d_swap_pulse_o is registered and is high in the cycle the new pointers appear.
- Reset mid-operation returns every register to its reset value on the next edge. A pending toggle is lost because the edge register resets to 0.

## Structure
- frame_ring_pkg holds MAIN/OVL base constants (8'h68 scaler, 8'h70 main, 8'h78 overlay), default parameters and the address-compose function.
- Sub-module frame_ring_sat_cnt: saturating counter with inc/clr, parameter CNT_W, instantiated twice.

## Test plan
- Reset, defaults -> wr=0, stages 1,2,3,4, ready=5; process_addr=8'h71, read_addr=8'h72, overlay_wr_addr=8'h7B.
- wr_done, then a swap 10 cycles later -> stages 0,1,2,3; ready=4; wr=5; swap_pulse high for 1 cycle; drop=0.
- Swap edge and wr_done in the same cycle with ready_valid=0 -> stage0=0, wr=4, ready=5 unchanged; repeat=0.
- Two wr_done pulses before a swap -> drop=1; stage0 = the second slot written.
- d_freeze_i=1 across 3 swaps with one wr_done -> stages unchanged, repeat=3, ready_valid=1. Releasing freeze then one swap -> pipeline advances.
- CNT_W=4, 20 empty swaps -> repeat=15 (saturated). d_clr_cnt_i coinciding with a swap -> 0. d_min_delay_path_sel=1 after wr_done with wr=0 -> read_addr=8'h70.
